// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: shares one carry_bypass_adder between NREQ valid/ready
// requesters using round-robin arbitration.
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/ready          per-requester handshake (req_ready is combinational)
//   req_a/req_b/req_cin      packed per-requester operands, slot i at [i*W +: W]
//   resp_valid/ready         single response channel
//   resp_id                  index of the requester owning the response
//   resp_sum/cout/overflow   registered add result
//   busy                     high whenever the FSM is not IDLE
// carry_bypass_adder: combinational W-bit adder built from N-bit ripple
// blocks whose carry skips the block when every bit propagates.

module carry_bypass_adder #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum_c,
  output logic         cout_c
);

  localparam int unsigned NB = (W + N - 1) / N;

  for (genvar g = 0; g < int'(NB); g++) begin : g_blk
    localparam int unsigned LO = 32'(g) * N;
    localparam int unsigned BW = (LO + N > W) ? (W - LO) : N;

    logic          blk_cin;
    logic          blk_cout;
    logic          ripple_c;
    logic [BW-1:0] p;
    logic [BW-1:0] bs;

    if (g == 0) begin : g_first
      assign blk_cin = cin;
    end else begin : g_chain
      assign blk_cin = g_blk[g-1].blk_cout;
    end

    // Ripple through the block.
    always_comb begin
      p        = '0;
      bs       = '0;
      ripple_c = blk_cin;
      for (int j = 0; j < int'(BW); j++) begin
        p[j]     = a[LO+32'(j)] ^ b[LO+32'(j)];
        bs[j]    = p[j] ^ ripple_c;
        ripple_c = (a[LO+32'(j)] & b[LO+32'(j)]) | (p[j] & ripple_c);
      end
    end

    // All-propagate block forwards its carry-in directly.
    assign blk_cout       = (&p) ? blk_cin : ripple_c;
    assign sum_c[LO +: BW] = bs;
  end

  assign cout_c = g_blk[NB-1].blk_cout;

endmodule

module adder_rr_arbiter #(
  parameter int unsigned W    = 32,
  parameter int unsigned N    = 4,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [NREQ-1:0]   req_cin,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [IDW-1:0]    resp_id,
  output logic [W-1:0]      resp_sum,
  output logic              resp_cout,
  output logic              resp_overflow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q;
  logic [W-1:0]   op_a_q, op_b_q;
  logic           op_cin_q;
  logic [IDW-1:0] op_id_q;

  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic           accept;
  logic [W-1:0]   sum_c;
  logic           cout_c;
  logic           ovf_c;

  // (base + off) mod NREQ, for base < NREQ and off <= NREQ.
  function automatic logic [IDW-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    int unsigned s;
    s = base + off;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Cyclic search from rr_ptr; walking downward leaves the nearest hit.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(32'(rr_ptr_q), 32'(k))]) begin
        grant_any = 1'b1;
        grant_idx = wrap_idx(32'(rr_ptr_q), 32'(k));
      end
    end
  end

  // Next-state and grant strobe.
  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_any && !rst) begin
          req_ready[grant_idx] = 1'b1;
          accept               = 1'b1;
          state_d              = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  carry_bypass_adder #(.W(W), .N(N)) u_adder (
    .a      (op_a_q),
    .b      (op_b_q),
    .cin    (op_cin_q),
    .sum_c  (sum_c),
    .cout_c (cout_c)
  );

  assign ovf_c = (op_a_q[W-1] & op_b_q[W-1] & ~sum_c[W-1]) |
                 (~op_a_q[W-1] & ~op_b_q[W-1] & sum_c[W-1]);

  // State, operand capture and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      op_cin_q      <= 1'b0;
      op_id_q       <= '0;
      resp_valid    <= 1'b0;
      resp_id       <= '0;
      resp_sum      <= '0;
      resp_cout     <= 1'b0;
      resp_overflow <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q    <= state_d;
      busy       <= (state_d != IDLE);
      resp_valid <= (state_d == RESP);
      if (accept) begin
        op_a_q   <= req_a[32'(grant_idx)*W +: W];
        op_b_q   <= req_b[32'(grant_idx)*W +: W];
        op_cin_q <= req_cin[grant_idx];
        op_id_q  <= grant_idx;
        rr_ptr_q <= wrap_idx(32'(grant_idx), 32'd1);
      end
      if (state_q == EXEC) begin
        resp_id       <= op_id_q;
        resp_sum      <= sum_c;
        resp_cout     <= cout_c;
        resp_overflow <= ovf_c;
      end
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Self-checking bench for adder_rr_arbiter: a scoreboard fills on every grant
// and drains on every response handshake; scenario tasks check timing inline.
module tb_adder_rr_arbiter;

  localparam int unsigned W    = 32;
  localparam int unsigned N    = 4;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   req_cin;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [W-1:0]      resp_sum;
  logic              resp_cout;
  logic              resp_overflow;
  logic              busy;

  logic [W-1:0] a_drv [NREQ];
  logic [W-1:0] b_drv [NREQ];

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           cout;
    logic           ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_exp;
  exp_t mon_got;
  int   tests_run    = 0;
  int   tests_failed = 0;

  adder_rr_arbiter #(.W(W), .N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_cin       (req_cin),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_id       (resp_id),
    .resp_sum      (resp_sum),
    .resp_cout     (resp_cout),
    .resp_overflow (resp_overflow),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      req_a[i*W +: W] = a_drv[i];
      req_b[i*W +: W] = b_drv[i];
    end
  end

  // Reference add: plain wide addition plus the sign rule.
  function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin);
    logic [W:0] full;
    exp_t       e;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.id   = IDW'(id);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.ovf  = (a[W-1] & b[W-1] & ~e.sum[W-1]) | (~a[W-1] & ~b[W-1] & e.sum[W-1]);
    return e;
  endfunction

  // Scoreboard: push on grant, pop and compare on response handshake.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (req_ready != '0) begin
        tests_run++;
        if (!$onehot(req_ready) || ((req_ready & ~req_valid) != '0)) begin
          tests_failed++;
          $display("FAIL grant_onehot: req_ready=%b req_valid=%b", req_ready, req_valid);
        end
        for (int i = 0; i < int'(NREQ); i++)
          if (req_ready[i]) sb.push_back(model(i, a_drv[i], b_drv[i], req_cin[i]));
      end
      if (resp_valid && resp_ready) begin
        tests_run++;
        mon_got = {resp_id, resp_sum, resp_cout, resp_overflow};
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_stale: response %h with nothing outstanding", mon_got);
        end else begin
          mon_exp = sb.pop_front();
          if (mon_got !== mon_exp) begin
            tests_failed++;
            $display("FAIL sb_resp: got id=%0d sum=%h c=%b v=%b expected id=%0d sum=%h c=%b v=%b",
                     resp_id, resp_sum, resp_cout, resp_overflow,
                     mon_exp.id, mon_exp.sum, mon_exp.cout, mon_exp.ovf);
          end
        end
      end
    end
  end

  // Returns the granted index at the negedge of the grant cycle, or -1.
  task automatic wait_grant(output int idx);
    idx = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        for (int i = 0; i < int'(NREQ); i++) if (req_ready[i]) idx = i;
        return;
      end
    end
  endtask

  // Negedges until resp_valid is seen, or -1.
  task automatic wait_resp(output int cyc);
    cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        cyc = c;
        return;
      end
    end
  endtask

  // Issue one request from requester id and wait for its response.
  task automatic do_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, output int gidx, output int cyc);
    @(posedge clk); #1;
    a_drv[id]   = a;
    b_drv[id]   = b;
    req_cin[id] = cin;
    req_valid   = NREQ'(1) << id;
    wait_grant(gidx);
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(cyc);
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    req_valid  = '1;
    resp_ready = 1'b1;
    req_cin    = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      a_drv[i] = '0;
      b_drv[i] = '0;
    end
    @(negedge clk);
    tests_run++;
    if ({req_ready, resp_valid, resp_id, resp_sum, resp_cout, resp_overflow, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rdy=%b v=%b id=%0d sum=%h c=%b o=%b busy=%b expected all 0",
               req_ready, resp_valid, resp_id, resp_sum, resp_cout, resp_overflow, busy);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b0;
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: busy=%b resp_valid=%b expected 0 0", busy, resp_valid);
    end
  endtask

  task automatic test_round_robin();
    int gidx, cyc;
    for (int i = 0; i < int'(NREQ); i++) begin
      a_drv[i]   = W'(i * 1000 + 7);
      b_drv[i]   = W'(i * 3 + 32'h100);
      req_cin[i] = 1'(i);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = '1;
    for (int g = 0; g < 5; g++) begin
      wait_grant(gidx);
      tests_run++;
      if (gidx !== g % int'(NREQ)) begin
        tests_failed++;
        $display("FAIL rr_order: grant %0d went to %0d, expected %0d", g, gidx, g % int'(NREQ));
      end
      if (g == 4) begin
        @(posedge clk); #1;
        req_valid = '0;
      end
      wait_resp(cyc);
      tests_run++;
      if (cyc !== 2 || resp_id !== IDW'(g % int'(NREQ))) begin
        tests_failed++;
        $display("FAIL rr_resp: latency %0d id %0d, expected latency 2 id %0d",
                 cyc, resp_id, g % int'(NREQ));
      end
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    int gidx, cyc;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    a_drv[0]   = 32'd21;
    b_drv[0]   = 32'd10;
    req_cin[0] = 1'b0;
    req_valid  = 4'b0001;
    wait_grant(gidx);
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL single_grant: req_ready=%b expected 0001", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    tests_run++;
    if (req_ready !== '0 || resp_valid !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_exec: rdy=%b v=%b busy=%b expected 0000 0 1", req_ready, resp_valid, busy);
    end
    @(negedge clk);
    tests_run++;
    if ({resp_valid, resp_id, resp_sum, resp_cout, resp_overflow} !== {1'b1, 2'd0, 32'd31, 1'b0, 1'b0}) begin
      tests_failed++;
      $display("FAIL single_resp: v=%b id=%0d sum=%0d c=%b o=%b expected 1 0 31 0 0",
               resp_valid, resp_id, resp_sum, resp_cout, resp_overflow);
    end
    @(negedge clk);
    tests_run++;
    if (resp_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: v=%b busy=%b expected 0 0", resp_valid, busy);
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] ta [3] = '{32'h4000_0000, 32'hC000_0000, 32'h8000_0000};
    logic [W-1:0] es [3] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
    logic [1:0]   ecv [3] = '{2'b01, 2'b10, 2'b11};
    int gidx, cyc;
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      do_op(1, ta[k], ta[k], 1'b0, gidx, cyc);
      tests_run++;
      if (gidx !== 1 || cyc !== 2 || resp_sum !== es[k] || {resp_cout, resp_overflow} !== ecv[k]) begin
        tests_failed++;
        $display("FAIL overflow_%0d: grant %0d lat %0d sum=%h c=%b o=%b expected 1 2 %h %b",
                 k, gidx, cyc, resp_sum, resp_cout, resp_overflow, es[k], ecv[k]);
      end
    end
  endtask

  task automatic test_carry_wrap();
    logic [W-1:0] ta [2] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [W-1:0] tb [2] = '{32'h0000_0000, 32'h8000_0001};
    logic         tc [2] = '{1'b1, 1'b0};
    int gidx, cyc;
    resp_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      do_op(2, ta[k], tb[k], tc[k], gidx, cyc);
      tests_run++;
      if (gidx !== 2 || resp_sum !== 32'd0 || resp_cout !== 1'b1 || resp_overflow !== 1'b0) begin
        tests_failed++;
        $display("FAIL carry_wrap_%0d: grant %0d sum=%h c=%b o=%b expected 2 00000000 1 0",
                 k, gidx, resp_sum, resp_cout, resp_overflow);
      end
    end
  endtask

  // Random operands; every third case forces all-propagate so carries bypass.
  task automatic test_random();
    int id, gidx, cyc;
    logic [W-1:0] a, b;
    logic cin;
    exp_t e;
    resp_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      id  = int'($urandom_range(0, NREQ - 1));
      a   = $urandom;
      b   = (k % 3 == 0) ? ~a : $urandom;
      cin = 1'($urandom_range(0, 1));
      e   = model(id, a, b, cin);
      do_op(id, a, b, cin, gidx, cyc);
      tests_run++;
      if (gidx !== id || {resp_id, resp_sum, resp_cout, resp_overflow} !== e) begin
        tests_failed++;
        $display("FAIL random_%0d: grant %0d id=%0d sum=%h c=%b o=%b expected %0d %h %b %b",
                 k, gidx, resp_id, resp_sum, resp_cout, resp_overflow, id, e.sum, e.cout, e.ovf);
      end
    end
  endtask

  task automatic test_backpressure();
    int gidx, cyc;
    exp_t e;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    a_drv[3]   = 32'h1234_5678;
    b_drv[3]   = 32'h0FED_CBA9;
    req_cin[3] = 1'b1;
    a_drv[0]   = 32'h0000_0005;
    b_drv[0]   = 32'h0000_0006;
    req_cin[0] = 1'b0;
    e          = model(3, a_drv[3], b_drv[3], req_cin[3]);
    req_valid  = 4'b1000;
    wait_grant(gidx);
    tests_run++;
    if (gidx !== 3) begin
      tests_failed++;
      $display("FAIL bp_grant: granted %0d expected 3", gidx);
    end
    @(posedge clk); #1;
    req_valid = 4'b0001;
    wait_resp(cyc);
    for (int c = 0; c < 5; c++) begin
      tests_run++;
      if (resp_valid !== 1'b1 || req_ready !== '0 ||
          {resp_id, resp_sum, resp_cout, resp_overflow} !== e ||
          resp_sum !== 32'h2222_2222) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: v=%b rdy=%b id=%0d sum=%h expected 1 0000 3 22222222",
                 c, resp_valid, req_ready, resp_id, resp_sum);
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (req_ready !== 4'b0001 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_next_grant: rdy=%b v=%b expected 0001 0", req_ready, resp_valid);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(cyc);
    tests_run++;
    if (cyc !== 2 || resp_id !== 2'd0 || resp_sum !== 32'd11) begin
      tests_failed++;
      $display("FAIL bp_second: lat %0d id %0d sum %0d expected 2 0 11", cyc, resp_id, resp_sum);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int gidx, cyc;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    a_drv[1]  = 32'h0000_1111;
    b_drv[1]  = 32'h0000_2222;
    req_valid = 4'b0010;
    wait_grant(gidx);
    @(posedge clk); #1;
    req_valid = '0;
    rst       = 1'b1;
    #1;
    tests_run++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_async: v=%b busy=%b rdy=%b expected 0 0 0000", resp_valid, busy, req_ready);
    end
    @(negedge clk);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 4'b1110;
    wait_grant(gidx);
    tests_run++;
    if (gidx !== 1) begin
      tests_failed++;
      $display("FAIL rst_mid_ptr: granted %0d expected 1", gidx);
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_resp(cyc);
    tests_run++;
    if (cyc !== 2 || resp_id !== 2'd1 || resp_sum !== 32'h0000_3333) begin
      tests_failed++;
      $display("FAIL rst_mid_resp: lat %0d id %0d sum %h expected 2 1 00003333", cyc, resp_id, resp_sum);
    end
    do_op(2, 32'd100, 32'd23, 1'b1, gidx, cyc);
    tests_run++;
    if (gidx !== 2 || resp_id !== 2'd2 || resp_sum !== 32'd124) begin
      tests_failed++;
      $display("FAIL rst_mid_req2: grant %0d id %0d sum %0d expected 2 2 124", gidx, resp_id, resp_sum);
    end
    @(negedge clk);
    @(negedge clk);
    tests_run++;
    if (sb.size() != 0 || resp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL drain: %0d outstanding, resp_valid=%b expected 0 0", sb.size(), resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_overflow();
    test_carry_wrap();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
